// File: rtl/microsequencer_if.sv
// Microstore <-> microsequencer link: control-word sequencing fields and status in,
// registered state number and wait/trap status out.
interface microsequencer_if #(
    parameter int unsigned STATE_W = 7
);
    logic [2:0]         n_sel;
    logic               inv;
    logic               cond_sel;
    logic [STATE_W-1:0] cr_addr;
    logic [STATE_W-1:0] enc_state;
    logic               moc;
    logic               cond_flag;
    logic [STATE_W-1:0] current_state;
    logic               wait_timeout;
    logic               waiting;

    modport master (
        output n_sel, inv, cond_sel, cr_addr, enc_state, moc, cond_flag,
        input  current_state, wait_timeout, waiting
    );

    modport slave (
        input  n_sel, inv, cond_sel, cr_addr, enc_state, moc, cond_flag,
        output current_state, wait_timeout, waiting
    );
endinterface

// File: rtl/microsequencer.sv
// Next-state engine for the microprogrammed control unit, with a bounded
// wait-for-memory loop that traps to TRAP_STATE after MAX_WAIT consecutive waits.
module microsequencer #(
    parameter int unsigned        STATE_W     = 7,
    parameter logic [STATE_W-1:0] RESET_STATE = 7'd0,
    parameter logic [STATE_W-1:0] TRAP_STATE  = 7'd127,
    parameter int unsigned        MAX_WAIT    = 15
) (
    input logic              clk,
    input logic              reset,
    microsequencer_if.slave  bus
);
    typedef enum logic [2:0] {
        MODE_DISPATCH  = 3'b000,
        MODE_REFETCH   = 3'b001,
        MODE_JUMP      = 3'b010,
        MODE_INCREMENT = 3'b011,
        MODE_CBRANCH   = 3'b100,
        MODE_CDISPATCH = 3'b101,
        MODE_WAIT      = 3'b110,
        MODE_RESERVED  = 3'b111
    } mode_t;

    localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT - 1);

    logic [STATE_W-1:0] r_state;
    logic [7:0]         r_wait_cnt;
    logic               r_wait_timeout;

    mode_t              w_mode;
    logic               w_c;
    logic [STATE_W-1:0] w_inc;
    logic [STATE_W-1:0] w_next;
    logic               w_waiting;
    logic               w_trap;

    assign w_mode    = mode_t'(bus.n_sel);
    assign w_c       = (bus.cond_sel ? bus.cond_flag : bus.moc) ^ bus.inv;
    assign w_inc     = r_state + 1'b1;
    assign w_waiting = (w_mode == MODE_WAIT) && !w_c && !reset;
    // A satisfied condition never reaches here, so c=1 at the limit advances instead of trapping.
    assign w_trap    = w_waiting && (r_wait_cnt == WAIT_LIMIT);

    always_comb begin
        w_next = RESET_STATE;
        case (w_mode)
            MODE_DISPATCH:  w_next = bus.enc_state;
            MODE_REFETCH:   w_next = RESET_STATE;
            MODE_JUMP:      w_next = bus.cr_addr;
            MODE_INCREMENT: w_next = w_inc;
            MODE_CBRANCH:   w_next = w_c ? bus.cr_addr : w_inc;
            MODE_CDISPATCH: w_next = w_c ? bus.cr_addr : bus.enc_state;
            MODE_WAIT:      w_next = w_c ? w_inc : r_state;
            MODE_RESERVED:  w_next = RESET_STATE;
            default:        w_next = RESET_STATE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= RESET_STATE;
            r_wait_cnt     <= '0;
            r_wait_timeout <= 1'b0;
        end else begin
            r_wait_timeout <= w_trap;
            if (w_trap) begin
                r_state    <= TRAP_STATE;
                r_wait_cnt <= '0;
            end else begin
                r_state    <= w_next;
                r_wait_cnt <= w_waiting ? r_wait_cnt + 8'd1 : '0;
            end
        end
    end

    assign bus.current_state = r_state;
    assign bus.wait_timeout  = r_wait_timeout;
    assign bus.waiting       = w_waiting;
endmodule

// File: tb/tb_microsequencer.sv
// Directed bench for microsequencer: vector table for the single-cycle modes,
// hand-written sequences for wait timeout, condition-at-limit and reset mid-wait.
module tb_microsequencer;
    logic clk;
    logic reset;

    microsequencer_if #(.STATE_W(7)) bus ();

    microsequencer #(
        .STATE_W    (7),
        .RESET_STATE(7'd0),
        .TRAP_STATE (7'd127),
        .MAX_WAIT   (15)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [2:0] n_sel;
        logic       inv;
        logic       cond_sel;
        logic [6:0] cr_addr;
        logic [6:0] enc_state;
        logic       moc;
        logic       cond_flag;
        logic [6:0] exp_state;
        logic       exp_to;
        logic       exp_wait;
    } vec_t;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    vec_t vecs[$];

    task automatic check(input string nm, input int unsigned act, input int unsigned exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Drive at negedge, check combinational waiting, clock, then check registered outputs.
    task automatic apply(input vec_t v, input string nm);
        @(negedge clk);
        reset         = v.rst;
        bus.n_sel     = v.n_sel;
        bus.inv       = v.inv;
        bus.cond_sel  = v.cond_sel;
        bus.cr_addr   = v.cr_addr;
        bus.enc_state = v.enc_state;
        bus.moc       = v.moc;
        bus.cond_flag = v.cond_flag;
        #1;
        check({nm, ".waiting"}, 32'(bus.waiting), 32'(v.exp_wait));
        @(posedge clk);
        #1;
        check({nm, ".state"}, 32'(bus.current_state), 32'(v.exp_state));
        check({nm, ".timeout"}, 32'(bus.wait_timeout), 32'(v.exp_to));
    endtask

    function automatic vec_t mk(input logic rst, input logic [2:0] n_sel, input logic inv,
                                input logic cond_sel, input logic [6:0] cr, input logic [6:0] enc,
                                input logic moc, input logic flag, input logic [6:0] es,
                                input logic eto, input logic ew);
        vec_t v;
        v.rst = rst; v.n_sel = n_sel; v.inv = inv; v.cond_sel = cond_sel;
        v.cr_addr = cr; v.enc_state = enc; v.moc = moc; v.cond_flag = flag;
        v.exp_state = es; v.exp_to = eto; v.exp_wait = ew;
        return v;
    endfunction

    initial begin
        reset = 1'b1;
        bus.n_sel = 3'b011; bus.inv = 1'b0; bus.cond_sel = 1'b0;
        bus.cr_addr = '0; bus.enc_state = '0; bus.moc = 1'b0; bus.cond_flag = 1'b0;

        //         rst n_sel   inv cs  cr     enc     moc flg  state  to wait
        vecs.push_back(mk(1, 3'b011, 0, 0, 7'd0, 7'd0,  0, 0, 7'd0,  0, 0));
        vecs.push_back(mk(1, 3'b110, 0, 0, 7'd0, 7'd0,  0, 0, 7'd0,  0, 0));
        vecs.push_back(mk(0, 3'b011, 0, 0, 7'd0, 7'd0,  0, 0, 7'd1,  0, 0));
        vecs.push_back(mk(0, 3'b011, 0, 0, 7'd0, 7'd0,  0, 0, 7'd2,  0, 0));
        vecs.push_back(mk(0, 3'b011, 0, 0, 7'd0, 7'd0,  0, 0, 7'd3,  0, 0));
        vecs.push_back(mk(0, 3'b000, 0, 0, 7'd0, 7'd10, 0, 0, 7'd10, 0, 0));
        vecs.push_back(mk(0, 3'b010, 0, 0, 7'd5, 7'd0,  0, 0, 7'd5,  0, 0));
        vecs.push_back(mk(0, 3'b111, 0, 0, 7'd5, 7'd9,  0, 0, 7'd0,  0, 0));
        vecs.push_back(mk(0, 3'b010, 0, 0, 7'd6, 7'd0,  0, 0, 7'd6,  0, 0));
        vecs.push_back(mk(0, 3'b001, 0, 0, 7'd6, 7'd9,  0, 0, 7'd0,  0, 0));
        vecs.push_back(mk(0, 3'b010, 0, 0, 7'd4, 7'd0,  0, 0, 7'd4,  0, 0));
        vecs.push_back(mk(0, 3'b100, 0, 1, 7'd9, 7'd0,  0, 1, 7'd9,  0, 0));
        vecs.push_back(mk(0, 3'b010, 0, 0, 7'd4, 7'd0,  0, 0, 7'd4,  0, 0));
        vecs.push_back(mk(0, 3'b100, 1, 1, 7'd9, 7'd0,  0, 1, 7'd5,  0, 0));
        vecs.push_back(mk(0, 3'b101, 0, 1, 7'd9, 7'd11, 0, 0, 7'd11, 0, 0));
        vecs.push_back(mk(0, 3'b101, 0, 1, 7'd9, 7'd11, 0, 1, 7'd9,  0, 0));
        vecs.push_back(mk(0, 3'b100, 0, 0, 7'd2, 7'd0,  1, 0, 7'd2,  0, 0));
        vecs.push_back(mk(0, 3'b010, 0, 0, 7'd3, 7'd0,  0, 0, 7'd3,  0, 0));
        for (int i = 0; i < 4; i++)
            vecs.push_back(mk(0, 3'b110, 0, 0, 7'd0, 7'd0, 0, 0, 7'd3, 0, 1));
        vecs.push_back(mk(0, 3'b110, 0, 0, 7'd0, 7'd0,  1, 0, 7'd4,  0, 0));
        vecs.push_back(mk(0, 3'b110, 1, 1, 7'd0, 7'd0,  0, 0, 7'd5,  0, 0));
        vecs.push_back(mk(0, 3'b110, 1, 1, 7'd0, 7'd0,  0, 1, 7'd5,  0, 1));

        foreach (vecs[i]) apply(vecs[i], $sformatf("vec%0d", i));

        // Timeout: 14 holds, trap on the 15th wait edge, pulse lasts one cycle, then wrap.
        apply(mk(0, 3'b010, 0, 0, 7'd3, 7'd0, 0, 0, 7'd3, 0, 0), "to.jump");
        for (int i = 0; i < 14; i++)
            apply(mk(0, 3'b110, 0, 0, 7'd0, 7'd0, 0, 0, 7'd3, 0, 1), $sformatf("to.hold%0d", i));
        apply(mk(0, 3'b110, 0, 0, 7'd0, 7'd0, 0, 0, 7'd127, 1, 1), "to.trap");
        apply(mk(0, 3'b011, 0, 0, 7'd0, 7'd0, 0, 0, 7'd0, 0, 0), "to.wrap");
        apply(mk(0, 3'b011, 0, 0, 7'd0, 7'd0, 0, 0, 7'd1, 0, 0), "to.after");

        // Condition arriving at the limit wins over the trap.
        apply(mk(0, 3'b010, 0, 0, 7'd3, 7'd0, 0, 0, 7'd3, 0, 0), "lim.jump");
        for (int i = 0; i < 14; i++)
            apply(mk(0, 3'b110, 0, 0, 7'd0, 7'd0, 0, 0, 7'd3, 0, 1), $sformatf("lim.hold%0d", i));
        apply(mk(0, 3'b110, 0, 0, 7'd0, 7'd0, 1, 0, 7'd4, 0, 0), "lim.cond");

        // Waiting in TRAP_STATE is ordinary; c=1 increments with wrap.
        apply(mk(0, 3'b010, 0, 0, 7'd127, 7'd0, 0, 0, 7'd127, 0, 0), "tw.jump");
        apply(mk(0, 3'b110, 0, 0, 7'd0, 7'd0, 0, 0, 7'd127, 0, 1), "tw.hold");
        apply(mk(0, 3'b110, 0, 0, 7'd0, 7'd0, 1, 0, 7'd0, 0, 0), "tw.go");

        // Reset mid-wait clears the counter: a full 15 fresh waits are needed to trap.
        apply(mk(0, 3'b010, 0, 0, 7'd3, 7'd0, 0, 0, 7'd3, 0, 0), "rw.jump");
        for (int i = 0; i < 7; i++)
            apply(mk(0, 3'b110, 0, 0, 7'd0, 7'd0, 0, 0, 7'd3, 0, 1), $sformatf("rw.hold%0d", i));
        apply(mk(1, 3'b110, 0, 0, 7'd0, 7'd0, 0, 0, 7'd0, 0, 0), "rw.reset");
        for (int i = 0; i < 14; i++)
            apply(mk(0, 3'b110, 0, 0, 7'd0, 7'd0, 0, 0, 7'd0, 0, 1), $sformatf("rw.hold2_%0d", i));
        apply(mk(0, 3'b110, 0, 0, 7'd0, 7'd0, 0, 0, 7'd127, 1, 1), "rw.trap");
        apply(mk(0, 3'b010, 0, 0, 7'd8, 7'd0, 0, 0, 7'd8, 0, 0), "rw.clear");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
